// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) arithmetic, S-boxes, round constants, FSM encoding.
package aes_pkg;

  localparam int unsigned AES_KEY_W = 128;
  localparam int unsigned AES_NR    = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2
  } state_t;

  // Indexed 1..10; remaining entries padded so any 4-bit counter indexes safely.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] r;
    t = a;
    r = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] state_in,
  input  logic [AES_KEY_W-1:0] round_key,
  input  logic                 last,
  output logic [AES_KEY_W-1:0] state_out
);

  logic [AES_KEY_W-1:0] isb;
  logic [AES_KEY_W-1:0] ark;
  logic [AES_KEY_W-1:0] imc;
  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    isb = '0;
    imc = '0;
    a0  = '0;
    a1  = '0;
    a2  = '0;
    a3  = '0;
    // Byte 4c+r takes row r from column (c-r) mod 4 of the input.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        isb[127 - 8*(4*c + r) -: 8] = inv_sbox(state_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
      end
    end
    ark = isb ^ round_key;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = ark[127 - 32*c -: 8];
      a1 = ark[119 - 32*c -: 8];
      a2 = ark[111 - 32*c -: 8];
      a3 = ark[103 - 32*c -: 8];
      imc[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      imc[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      imc[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      imc[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    state_out = last ? ark : imc;
  end

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryption with on-the-fly round keys (forward expansion, then inverse walk).
// Optional AES_DEC_KEY_CACHE_EN keeps the last expanded rk10 to skip KEYEXP on a repeated key.
module aes_dec_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic [AES_KEY_W-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [AES_KEY_W-1:0] data_out
);

  if (NR != 10) begin : g_nr_check
    $error("aes_dec_iter supports only NR=10 (AES-128)");
  end

  localparam logic [3:0] LAST_CNT = 4'(NR);

  state_t               state;
  logic [AES_KEY_W-1:0] key_r;
  logic [AES_KEY_W-1:0] text_r;
  logic [3:0]           cnt;
  logic [AES_KEY_W-1:0] key_fwd;
  logic [AES_KEY_W-1:0] key_inv;
  logic [AES_KEY_W-1:0] round_out;
  logic [31:0]          w0, w1, w2, w3, f0, i3;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [AES_KEY_W-1:0] cache_key;
  logic [AES_KEY_W-1:0] cache_rk10;
  logic                 cache_vld;
`endif

  always_comb begin
    {w0, w1, w2, w3} = key_r;
    f0      = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {RCON[cnt], 24'h0};
    key_fwd = {f0, w1 ^ f0, w2 ^ w1 ^ f0, w3 ^ w2 ^ w1 ^ f0};
    i3      = w3 ^ w2;
    key_inv = {w0 ^ sub_word({i3[23:0], i3[31:24]}) ^ {RCON[cnt], 24'h0}, w1 ^ w0, w2 ^ w1, i3};
  end

  aes_inv_round u_round (
    .state_in  (text_r),
    .round_key (key_inv),
    .last      (cnt == 4'd1),
    .state_out (round_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      key_r    <= '0;
      text_r   <= '0;
      cnt      <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key  <= '0;
      cache_rk10 <= '0;
      cache_vld  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_vld && key_in == cache_key) begin
              key_r  <= cache_rk10;
              text_r <= data_in ^ cache_rk10;
              cnt    <= LAST_CNT;
              state  <= ROUND;
            end else begin
              key_r     <= key_in;
              text_r    <= data_in;
              cnt       <= 4'd1;
              state     <= KEYEXP;
              cache_key <= key_in;
              cache_vld <= 1'b0;
            end
`else
            key_r  <= key_in;
            text_r <= data_in;
            cnt    <= 4'd1;
            state  <= KEYEXP;
`endif
          end
        end
        KEYEXP: begin
          key_r <= key_fwd;
          if (cnt == LAST_CNT) begin
            text_r <= text_r ^ key_fwd;
            state  <= ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_rk10 <= key_fwd;
            cache_vld  <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          text_r <= round_out;
          key_r  <= key_inv;
          cnt    <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            data_out <= round_out;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed bench for aes_dec_iter: scoreboard of expected plaintext and completion cycle.
module tb_aes_dec_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] data_in;
  logic         busy;
  logic         done;
  logic [127:0] data_out;

  typedef struct {
    logic [127:0] pt;
    int unsigned  due;
  } exp_t;

  exp_t         sb[$];
  int unsigned  cyc = 0;
  int           checks = 0;
  int           fails = 0;
  int unsigned  done_cnt = 0;
  logic         done_prev = 1'b0;
  logic         m_vld = 1'b0;
  logic [127:0] m_key = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_dec_iter #(.NR(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      checks++;
      assert (done_prev === 1'b0) else begin
        fails++; $error("FAIL done_pulse_width observed=%b required=0 cycle=%0d", done_prev, cyc);
      end
      checks++;
      assert (sb.size() != 0) else begin
        fails++; $error("FAIL unexpected_done observed=1 required=0 cycle=%0d", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert (data_out === e.pt) else begin
          fails++; $error("FAIL plaintext observed=%h required=%h", data_out, e.pt);
        end
        checks++;
        assert (cyc === e.due) else begin
          fails++; $error("FAIL done_cycle observed=%0d required=%0d", cyc, e.due);
        end
      end
    end
    done_prev = done;
  end

  function automatic int unsigned model_lat(input logic [127:0] key);
`ifdef AES_DEC_KEY_CACHE_EN
    return (m_vld && key == m_key) ? 10 : 20;
`else
    return 20;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; the accepting edge is the next posedge.
  task automatic accept(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt,
                        input int unsigned acc, output int unsigned lat);
    exp_t e;
    key_in  = k;
    data_in = ct;
    start   = 1'b1;
    lat     = model_lat(k);
    e.pt    = pt;
    e.due   = acc + lat;
    sb.push_back(e);
    if (lat == 20) begin
      m_key = k;
      m_vld = 1'b1;
    end
  endtask

  task automatic run_block(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
    int unsigned lat;
    int unsigned nb;
    int unsigned n;
    accept(k, ct, pt, cyc + 1, lat);
    tick();
    start = 1'b0;
    nb = 0;
    n  = 0;
    while (!done && n < 200) begin
      if (busy) nb++;
      tick();
      n++;
    end
    checks++;
    assert (done === 1'b1) else begin
      fails++; $error("FAIL done_timeout observed=%b required=1", done);
    end
    checks++;
    assert (nb === lat) else begin
      fails++; $error("FAIL busy_cycles observed=%0d required=%0d", nb, lat);
    end
    checks++;
    assert (busy === 1'b0) else begin
      fails++; $error("FAIL busy_at_done observed=%b required=0", busy);
    end
    tick();
  endtask

  initial begin
    int unsigned acc;
    int unsigned lat1;
    int unsigned lat2;
    int unsigned base;
    int unsigned n;

    rst = 1'b1; start = 1'b0; key_in = '0; data_in = '0;
    tick(); tick();
    checks++; assert (busy === 1'b0) else begin fails++; $error("FAIL reset_busy observed=%b required=0", busy); end
    checks++; assert (done === 1'b0) else begin fails++; $error("FAIL reset_done observed=%b required=0", done); end
    checks++; assert (data_out === 128'h0) else begin fails++; $error("FAIL reset_data observed=%h required=0", data_out); end
    rst = 1'b0;
    tick();

    run_block(C1_KEY, C1_CT, C1_PT);
    run_block(B_KEY, B_CT, B_PT);

    // Start pulses on every busy cycle must be ignored.
    base = done_cnt;
    accept(C1_KEY, C1_CT, C1_PT, cyc + 1, lat1);
    tick();
    n = 0;
    while (!done && n < 200) begin
      start   = busy;
      key_in  = {$urandom, $urandom, $urandom, $urandom};
      data_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    start = 1'b0;
    repeat (30) tick();
    checks++;
    assert (done_cnt === base + 1) else begin
      fails++; $error("FAIL spam_done_count observed=%0d required=%0d", done_cnt - base, 1);
    end

    // Reset in the middle of an operation discards it.
    acc = cyc + 1;
    accept(C1_KEY, C1_CT, C1_PT, acc, lat1);
    tick();
    start = 1'b0;
    while (cyc < acc + 7) tick();
    rst = 1'b1;
    tick();
    sb.delete();
    m_vld = 1'b0;
    checks++; assert (busy === 1'b0) else begin fails++; $error("FAIL midrst_busy observed=%b required=0", busy); end
    checks++; assert (data_out === 128'h0) else begin fails++; $error("FAIL midrst_data observed=%h required=0", data_out); end
    rst = 1'b0;
    base = done_cnt;
    repeat (30) tick();
    checks++;
    assert (done_cnt === base) else begin
      fails++; $error("FAIL midrst_done observed=%0d required=0", done_cnt - base);
    end
    run_block(C1_KEY, C1_CT, C1_PT);

    // Back-to-back: start held high, second block accepted at the edge ending done.
    base = done_cnt;
    acc = cyc + 1;
    accept(C1_KEY, C1_CT, C1_PT, acc, lat1);
    tick();
    accept(B_KEY, B_CT, B_PT, acc + lat1 + 1, lat2);
    n = 0;
    while (cyc < acc + lat1 + 1 && n < 200) begin
      tick();
      n++;
    end
    start = 1'b0;
    n = 0;
    while (done_cnt < base + 2 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    assert (done_cnt === base + 2) else begin
      fails++; $error("FAIL b2b_done_count observed=%0d required=2", done_cnt - base);
    end
    tick();

    // Repeated key (cache hit when enabled), then a key change.
    run_block(C1_KEY, C1_CT, C1_PT);
    run_block(C1_KEY, C1_CT, C1_PT);
    run_block(B_KEY, B_CT, B_PT);

    repeat (5) tick();
    checks++;
    assert (sb.size() === 0) else begin
      fails++; $error("FAIL pending_results observed=%0d required=0", sb.size());
    end
    checks++;
    assert (data_out === B_PT) else begin
      fails++; $error("FAIL data_hold observed=%h required=%h", data_out, B_PT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
